// File: rtl/hazard_control_unit.sv
// -----------------------------------------------------------------------------
// hazard_control_unit
//
// Sits on the consuming side of the ID/EX pipeline register. It looks at the
// fields leaving ID/EX and at the instruction waiting in IF/ID, and returns
// stall and flush controls for the PC, IF/ID and ID/EX registers.
//
// Two hazard classes are handled:
//   * load-use: a load in EX whose destination feeds the instruction in ID.
//     The front end is frozen and a bubble goes into ID/EX for exactly
//     LOAD_STALL_CYCLES cycles, which covers slow data memory.
//   * redirect: a taken branch or a jump resolved in EX. IF/ID and ID/EX are
//     flushed while the PC loads the new target.
// Two saturating event counters (stall cycles, redirects) support
// performance debug.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (>= 1)
//   COUNTER_WIDTH      width of stall_count_o / flush_count_o
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous reset, active low
//   idex_mem_read_i  load in EX (mem_read leaving ID/EX)
//   idex_rt_i        destination of that load
//   ifid_rs_i        Rs of the instruction in IF/ID
//   ifid_rt_i        Rt of the instruction in IF/ID
//   ifid_uses_rt_i   IF/ID instruction actually reads Rt
//   branch_taken_i   branch taken, resolved in EX
//   jmp_i            jump leaving ID/EX
//   cnt_clear_i      synchronous clear of both counters
//   pc_write_o       PC load enable
//   ifid_write_o     IF/ID load enable
//   ifid_flush_o     IF/ID flush
//   idex_flush_o     ID/EX flush (bubble insert)
//   state_o          00 RUN, 01 STALL
//   stall_count_o    stall cycles seen, saturating
//   flush_count_o    redirects seen, saturating
// -----------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int COUNTER_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     idex_mem_read_i,
    input  logic [4:0]               idex_rt_i,
    input  logic [4:0]               ifid_rs_i,
    input  logic [4:0]               ifid_rt_i,
    input  logic                     ifid_uses_rt_i,
    input  logic                     branch_taken_i,
    input  logic                     jmp_i,
    input  logic                     cnt_clear_i,
    output logic                     pc_write_o,
    output logic                     ifid_write_o,
    output logic                     ifid_flush_o,
    output logic                     idex_flush_o,
    output logic [1:0]               state_o,
    output logic [COUNTER_WIDTH-1:0] stall_count_o,
    output logic [COUNTER_WIDTH-1:0] flush_count_o
);

    // The remaining-cycles register only has to hold LOAD_STALL_CYCLES-1.
    localparam int REM_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01
    } state_e;

    state_e                   state_q, state_d;
    logic [REM_W-1:0]         remaining_q, remaining_d;
    logic [COUNTER_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [COUNTER_WIDTH-1:0] flush_count_q, flush_count_d;

    logic load_use;
    logic redirect;
    logic stall_inc;
    logic flush_inc;

    // Register 0 is hard-wired, so a load targeting it never creates a real
    // dependency. Rt only matters when the consumer actually reads it.
    assign load_use = idex_mem_read_i
                    & (idex_rt_i != 5'd0)
                    & ((idex_rt_i == ifid_rs_i)
                       | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));

    assign redirect = branch_taken_i | jmp_i;

    // Control decode and next-state logic. Outputs are combinational so the
    // pipeline registers see them in the same cycle the hazard appears.
    // While reset is held every enable and flush is forced low. A redirect
    // always wins: the stalled instruction is on the wrong path anyway. Once
    // in STALL the hazard compare is ignored; the countdown alone decides
    // when the front end is released.
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        state_d      = state_q;
        remaining_d  = remaining_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (!reset) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            state_d      = ST_RUN;
            remaining_d  = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (redirect) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                        stall_inc    = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d     = ST_STALL;
                            remaining_d = REM_W'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                ST_STALL: begin
                    if (redirect) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                        flush_inc    = 1'b1;
                        state_d      = ST_RUN;
                        remaining_d  = '0;
                    end else begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                        stall_inc    = 1'b1;
                        remaining_d  = remaining_q - REM_W'(1);
                        if (remaining_q == REM_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d     = ST_RUN;
                    remaining_d = '0;
                end
            endcase
        end
    end

    // Event counters: a clear in the same cycle as an event leaves zero, and
    // an all-ones counter holds instead of wrapping.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (cnt_clear_i) begin
            stall_count_d = '0;
            flush_count_d = '0;
        end else begin
            if (stall_inc && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + COUNTER_WIDTH'(1);
            end
            if (flush_inc && (flush_count_q != '1)) begin
                flush_count_d = flush_count_q + COUNTER_WIDTH'(1);
            end
        end
    end

    // State registers. Reset drops any stall in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            remaining_q   <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign state_o       = state_q;
    assign stall_count_o = stall_count_q;
    assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit. Two instances share one set of inputs:
//   dutA: LOAD_STALL_CYCLES=1, COUNTER_WIDTH=4  (single bubble, saturation)
//   dutB: LOAD_STALL_CYCLES=3, COUNTER_WIDTH=16 (multi-cycle stall)
// A behavioural model tracks, per instance, how many stall cycles are still
// owed and the two event counts as plain integers.
module tb_hazard_control_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       memRead;
   logic [4:0] idexRt;
   logic [4:0] ifidRs;
   logic [4:0] ifidRt;
   logic       usesRt;
   logic       branchTaken;
   logic       jmp;
   logic       cntClear;

   logic        pcWriteA, ifidWriteA, ifidFlushA, idexFlushA;
   logic [1:0]  stateA;
   logic [3:0]  stallCntA, flushCntA;
   logic        pcWriteB, ifidWriteB, ifidFlushB, idexFlushB;
   logic [1:0]  stateB;
   logic [15:0] stallCntB, flushCntB;

   hazard_control_unit #(.LOAD_STALL_CYCLES(1), .COUNTER_WIDTH(4)) dutA (
      .clk(clk), .reset(reset),
      .idex_mem_read_i(memRead), .idex_rt_i(idexRt),
      .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt), .ifid_uses_rt_i(usesRt),
      .branch_taken_i(branchTaken), .jmp_i(jmp), .cnt_clear_i(cntClear),
      .pc_write_o(pcWriteA), .ifid_write_o(ifidWriteA),
      .ifid_flush_o(ifidFlushA), .idex_flush_o(idexFlushA),
      .state_o(stateA), .stall_count_o(stallCntA), .flush_count_o(flushCntA));

   hazard_control_unit #(.LOAD_STALL_CYCLES(3), .COUNTER_WIDTH(16)) dutB (
      .clk(clk), .reset(reset),
      .idex_mem_read_i(memRead), .idex_rt_i(idexRt),
      .ifid_rs_i(ifidRs), .ifid_rt_i(ifidRt), .ifid_uses_rt_i(usesRt),
      .branch_taken_i(branchTaken), .jmp_i(jmp), .cnt_clear_i(cntClear),
      .pc_write_o(pcWriteB), .ifid_write_o(ifidWriteB),
      .ifid_flush_o(ifidFlushB), .idex_flush_o(idexFlushB),
      .state_o(stateB), .stall_count_o(stallCntB), .flush_count_o(flushCntB));

   int checks = 0;
   int errors = 0;

   // Behavioural model state, index 0 = dutA, 1 = dutB.
   int owed[2];
   int stallEv[2];
   int flushEv[2];
   int lsc[2]    = '{1, 3};
   int cntMax[2] = '{15, 65535};

   // Outputs captured mid-cycle by applyStimulus for hand-written checks.
   logic [3:0] sampCtlA, sampCtlB;
   logic [1:0] sampStateA, sampStateB;

   // One table row: inputs plus the control nibble {pc,ifid_w,ifid_f,idex_f}
   // expected from dutA, whose single-bubble behaviour is memoryless.
   typedef struct {
      logic       rst;
      logic       mr;
      logic [4:0] rt;
      logic [4:0] rs;
      logic [4:0] irt;
      logic       uses;
      logic       br;
      logic       jp;
      logic       clr;
      logic [3:0] expCtl;
   } vec_t;

   function automatic vec_t mkVec(bit rst, bit mr, int rt, int rs, int irt,
                                  bit uses, bit br, bit jp, bit clr, logic [3:0] expCtl);
      vec_t v;
      v.rst = rst; v.mr = mr; v.rt = 5'(rt); v.rs = 5'(rs); v.irt = 5'(irt);
      v.uses = uses; v.br = br; v.jp = jp; v.clr = clr; v.expCtl = expCtl;
      return v;
   endfunction

   function automatic bit loadUseNow();
      return memRead && (idexRt != 0) &&
             ((idexRt == ifidRs) || (usesRt && (idexRt == ifidRt)));
   endfunction

   task automatic checkOutput(string name, int actual, int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         owed[d] = 0; stallEv[d] = 0; flushEv[d] = 0;
      end
   endtask

   // Compare both instances against the model for the current cycle.
   task automatic modelCheck();
      for (int d = 0; d < 2; d++) begin
         logic [3:0] expCtl;
         logic [3:0] actCtl;
         int actState, actStall, actFlush;
         bit redir = branchTaken || jmp;
         bit stalling = owed[d] > 0;
         if (!reset)                     expCtl = 4'b0000;
         else if (redir)                 expCtl = 4'b1111;
         else if (stalling || loadUseNow()) expCtl = 4'b0001;
         else                            expCtl = 4'b1100;
         if (d == 0) begin
            actCtl = {pcWriteA, ifidWriteA, ifidFlushA, idexFlushA};
            actState = int'(stateA); actStall = int'(stallCntA); actFlush = int'(flushCntA);
         end else begin
            actCtl = {pcWriteB, ifidWriteB, ifidFlushB, idexFlushB};
            actState = int'(stateB); actStall = int'(stallCntB); actFlush = int'(flushCntB);
         end
         checkOutput($sformatf("model_ctl_dut%0d", d), int'(actCtl), int'(expCtl));
         checkOutput($sformatf("model_state_dut%0d", d), actState, stalling ? 1 : 0);
         checkOutput($sformatf("model_stallcnt_dut%0d", d), actStall, stallEv[d]);
         checkOutput($sformatf("model_flushcnt_dut%0d", d), actFlush, flushEv[d]);
      end
   endtask

   // Advance the model by one clock edge with the present inputs.
   task automatic modelUpdate();
      if (!reset) begin
         modelReset();
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (branchTaken || jmp) begin
               if (flushEv[d] < cntMax[d]) flushEv[d]++;
               owed[d] = 0;
            end else if (owed[d] > 0) begin
               if (stallEv[d] < cntMax[d]) stallEv[d]++;
               owed[d]--;
            end else if (loadUseNow()) begin
               if (stallEv[d] < cntMax[d]) stallEv[d]++;
               owed[d] = lsc[d] - 1;
            end
            if (cntClear) begin
               stallEv[d] = 0;
               flushEv[d] = 0;
            end
         end
      end
   endtask

   // Drive one cycle of inputs, check mid-cycle, then step across the edge.
   task automatic applyStimulus(vec_t v);
      reset = v.rst; memRead = v.mr; idexRt = v.rt; ifidRs = v.rs; ifidRt = v.irt;
      usesRt = v.uses; branchTaken = v.br; jmp = v.jp; cntClear = v.clr;
      #1;
      if (!reset) modelReset();
      @(negedge clk);
      sampCtlA   = {pcWriteA, ifidWriteA, ifidFlushA, idexFlushA};
      sampCtlB   = {pcWriteB, ifidWriteB, ifidFlushB, idexFlushB};
      sampStateA = stateA;
      sampStateB = stateB;
      modelCheck();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   vec_t tbl[12];
   vec_t idle, hazard, rstHaz;

   initial begin
      idle   = mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100);
      hazard = mkVec(1, 1, 5, 5, 0, 0, 0, 0, 0, 4'b0001);
      rstHaz = mkVec(0, 1, 5, 5, 0, 0, 0, 0, 0, 4'b0000);

      tbl[0]  = rstHaz;
      tbl[1]  = idle;
      tbl[2]  = hazard;
      tbl[3]  = mkVec(1, 1, 0, 0, 0, 1, 0, 0, 0, 4'b1100);
      tbl[4]  = mkVec(1, 1, 7, 3, 7, 0, 0, 0, 0, 4'b1100);
      tbl[5]  = mkVec(1, 1, 7, 3, 7, 1, 0, 0, 0, 4'b0001);
      tbl[6]  = mkVec(1, 0, 5, 5, 5, 1, 0, 0, 0, 4'b1100);
      tbl[7]  = mkVec(1, 1, 5, 5, 0, 0, 1, 0, 0, 4'b1111);
      tbl[8]  = mkVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1111);
      tbl[9]  = mkVec(1, 1, 31, 31, 2, 0, 0, 0, 0, 4'b0001);
      tbl[10] = mkVec(1, 1, 9, 4, 9, 1, 0, 1, 1, 4'b1111);
      tbl[11] = idle;

      // Reset held with a live hazard: everything low, counters zero.
      applyStimulus(rstHaz);
      checkOutput("reset_ctlA", int'(sampCtlA), 0);
      checkOutput("reset_ctlB", int'(sampCtlB), 0);
      checkOutput("reset_stallA", int'(stallCntA), 0);
      checkOutput("reset_flushB", int'(flushCntB), 0);

      // Decode table (dutA expectations; dutB is covered by the model).
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("table%0d_ctlA", i), int'(sampCtlA), int'(tbl[i].expCtl));
         checkOutput($sformatf("table%0d_stateA", i), int'(sampStateA), 0);
      end

      // LSC=3: one hazard gives three stall cycles then RUN.
      applyStimulus(rstHaz);
      applyStimulus(hazard);
      checkOutput("lsc3_c0_state", int'(sampStateB), 0);
      checkOutput("lsc3_c0_ctl", int'(sampCtlB), 4'b0001);
      checkOutput("lsc1_c0_stall", int'(stallCntA), 1);
      applyStimulus(idle);
      checkOutput("lsc3_c1_state", int'(sampStateB), 1);
      checkOutput("lsc3_c1_ctl", int'(sampCtlB), 4'b0001);
      checkOutput("lsc1_c1_ctl", int'(sampCtlA), 4'b1100);
      applyStimulus(idle);
      checkOutput("lsc3_c2_state", int'(sampStateB), 1);
      checkOutput("lsc3_c2_ctl", int'(sampCtlB), 4'b0001);
      applyStimulus(idle);
      checkOutput("lsc3_c3_state", int'(sampStateB), 0);
      checkOutput("lsc3_c3_ctl", int'(sampCtlB), 4'b1100);
      checkOutput("lsc3_stallcnt", int'(stallCntB), 3);
      applyStimulus(mkVec(1, 1, 0, 0, 0, 1, 0, 0, 0, 4'b1100));
      checkOutput("lsc3_rt0_ctl", int'(sampCtlB), 4'b1100);

      // Branch together with load-use: redirect wins.
      applyStimulus(rstHaz);
      applyStimulus(mkVec(1, 1, 5, 5, 0, 0, 1, 0, 0, 4'b1111));
      checkOutput("brlu_ctlA", int'(sampCtlA), 4'b1111);
      checkOutput("brlu_ctlB", int'(sampCtlB), 4'b1111);
      checkOutput("brlu_flushA", int'(flushCntA), 1);
      checkOutput("brlu_stallA", int'(stallCntA), 0);

      // Saturation on the 4-bit counter, then clear beating an increment.
      applyStimulus(rstHaz);
      for (int i = 0; i < 20; i++) applyStimulus(hazard);
      checkOutput("sat_stallA", int'(stallCntA), 15);
      applyStimulus(mkVec(1, 1, 5, 5, 0, 0, 0, 0, 1, 4'b0001));
      checkOutput("clear_stallA", int'(stallCntA), 0);
      checkOutput("clear_stallB", int'(stallCntB), 0);

      // Reset pulse during the second STALL cycle of dutB.
      applyStimulus(rstHaz);
      applyStimulus(hazard);
      applyStimulus(idle);
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
      checkOutput("midrst_ctlB", int'(sampCtlB), 0);
      checkOutput("midrst_stateB", int'(sampStateB), 0);
      checkOutput("midrst_stallB", int'(stallCntB), 0);
      applyStimulus(idle);
      checkOutput("postrst_stateB", int'(sampStateB), 0);
      checkOutput("postrst_ctlB", int'(sampCtlB), 4'b1100);

      // Randomized traffic against the model. Small register numbers make
      // dependencies frequent.
      for (int i = 0; i < 2000; i++) begin
         vec_t r;
         r = mkVec($urandom_range(0, 99) != 0, $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                   $urandom_range(0, 11) == 0, $urandom_range(0, 40) == 0, 4'b0000);
         applyStimulus(r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net in case the run never reaches the summary.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
